// File: rtl/grn_pkg.sv
// Shared definitions for the GRN cycle-detection controller.
// FSM encodings stay numeric so that legacy code that decodes state values keeps working.
package grn_pkg;

    localparam int unsigned GRN_CNT_W = 16;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LOAD   = 3'd1;
    localparam logic [2:0] ST_SEARCH = 3'd2;
    localparam logic [2:0] ST_PERIOD = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

endpackage

// File: rtl/grn_cycle_ctrl.sv
// Floyd cycle-detection sequencer for an array of dual-state GRN nodes.
// The tortoise (s0) advances on alternate starts inside each node; the hare (s1) advances on every start.
module grn_cycle_ctrl
    import grn_pkg::*;
#(
    parameter int unsigned N_NODES   = 4,
    parameter int unsigned CNT_W     = GRN_CNT_W,
    parameter int unsigned MAX_STEPS = 1000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               init_valid,
    output logic               init_ready,
    input  logic [N_NODES-1:0] init_data,
    output logic               node_reset_nos,
    output logic [N_NODES-1:0] node_init_state,
    output logic               node_start_s0,
    output logic               node_start_s1,
    input  logic [N_NODES-1:0] syk_s0,
    input  logic [N_NODES-1:0] syk_s1,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [CNT_W-1:0]   res_meet,
    output logic [CNT_W-1:0]   res_period,
    output logic               res_timeout
);

    localparam logic [CNT_W-1:0] MAX_M = CNT_W'(MAX_STEPS);

    logic [2:0]         state_q, state_d;
    logic               phase_q, phase_d;
    logic [CNT_W-1:0]   m_q, m_d;
    logic [CNT_W-1:0]   lam_q, lam_d;
    logic               init_ready_q, init_ready_d;
    logic               reset_nos_q, reset_nos_d;
    logic [N_NODES-1:0] init_state_q, init_state_d;
    logic               res_valid_q, res_valid_d;
    logic [CNT_W-1:0]   res_meet_q, res_meet_d;
    logic [CNT_W-1:0]   res_period_q, res_period_d;
    logic               res_timeout_q, res_timeout_d;
    logic               start_s0_c, start_s1_c;
    logic               states_eq;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

    assign states_eq = (syk_s0 == syk_s1);

    always_comb begin
        state_d       = state_q;
        phase_d       = phase_q;
        m_d           = m_q;
        lam_d         = lam_q;
        init_state_d  = init_state_q;
        res_meet_d    = res_meet_q;
        res_period_d  = res_period_q;
        res_timeout_d = res_timeout_q;
        start_s0_c    = 1'b0;
        start_s1_c    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (init_valid) begin
                    init_state_d = init_data;
                    state_d      = ST_LOAD;
                end
            end
            ST_LOAD: begin
                phase_d = 1'b1;
                m_d     = '0;
                state_d = ST_SEARCH;
            end
            ST_SEARCH: begin
                // phase==1 with m>=1 means an even number of edges: s0=x_m, s1=x_2m
                if (phase_q && (m_q != '0) && states_eq) begin
                    lam_d   = '0;
                    state_d = ST_PERIOD;
                end else if (phase_q && (m_q == MAX_M)) begin
                    res_meet_d    = m_q;
                    res_period_d  = '0;
                    res_timeout_d = 1'b1;
                    state_d       = ST_DONE;
                end else begin
                    start_s0_c = 1'b1;
                    start_s1_c = 1'b1;
                    phase_d    = ~phase_q;
                    if (phase_q) begin
                        m_d = sat_inc(m_q);
                    end
                end
            end
            ST_PERIOD: begin
                if ((lam_q != '0) && states_eq) begin
                    res_meet_d    = m_q;
                    res_period_d  = lam_q;
                    res_timeout_d = 1'b0;
                    state_d       = ST_DONE;
                end else begin
                    start_s1_c = 1'b1;
                    lam_d      = sat_inc(lam_q);
                end
            end
            ST_DONE: begin
                if (res_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        init_ready_d = (state_d == ST_IDLE);
        reset_nos_d  = (state_d == ST_LOAD);
        res_valid_d  = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            phase_q       <= 1'b1;
            m_q           <= '0;
            lam_q         <= '0;
            init_ready_q  <= 1'b1;
            reset_nos_q   <= 1'b0;
            init_state_q  <= '0;
            res_valid_q   <= 1'b0;
            res_meet_q    <= '0;
            res_period_q  <= '0;
            res_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            phase_q       <= phase_d;
            m_q           <= m_d;
            lam_q         <= lam_d;
            init_ready_q  <= init_ready_d;
            reset_nos_q   <= reset_nos_d;
            init_state_q  <= init_state_d;
            res_valid_q   <= res_valid_d;
            res_meet_q    <= res_meet_d;
            res_period_q  <= res_period_d;
            res_timeout_q <= res_timeout_d;
        end
    end

    assign init_ready      = init_ready_q;
    assign node_reset_nos  = reset_nos_q;
    assign node_init_state = init_state_q;
    assign node_start_s0   = start_s0_c;
    assign node_start_s1   = start_s1_c;
    assign res_valid       = res_valid_q;
    assign res_meet        = res_meet_q;
    assign res_period      = res_period_q;
    assign res_timeout     = res_timeout_q;

endmodule
